// File: rtl/br_err_event_log_pkg.sv
// Shared types for the error event logger: report FSM state encoding.
package br_err_event_log_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        OFFER = ST_OFFER
    } rpt_state_e;

endpackage

// File: rtl/br_err_event_log_prio_enc.sv
// Lowest-set-index encoder: returns the index of the lowest 1 bit and whether any bit is set.
module br_err_event_log_prio_enc #(
    parameter int NumSources = 8
) (
    input  logic [NumSources-1:0]         vec,
    output logic [$clog2(NumSources)-1:0] idx,
    output logic                          found
);

    localparam int IdWidth = $clog2(NumSources);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NumSources - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IdWidth'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/br_err_event_log.sv
// Error event logger: sticky per-source pending bits, saturating count, first-error capture, report drain.
// Optional first-error cycle stamp enabled by defining BR_ERR_EVENT_LOG_TIMESTAMP_EN.
module br_err_event_log
    import br_err_event_log_pkg::*;
#(
    parameter int NumSources = 8,
    parameter int CountWidth = 8,
    parameter int TimeWidth  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NumSources-1:0]         err_in,
    input  logic                          clear,
    output logic [NumSources-1:0]         pending,
    output logic                          any_err,
    output logic [CountWidth-1:0]         err_count,
    output logic                          first_valid,
    output logic [$clog2(NumSources)-1:0] first_id,
    output logic [TimeWidth-1:0]          first_time,
    output logic                          rpt_valid,
    input  logic                          rpt_ready,
    output logic [$clog2(NumSources)-1:0] rpt_id
);

    localparam int IdWidth  = $clog2(NumSources);
    localparam int PopWidth = IdWidth + 1;
    localparam int SumWidth = CountWidth + PopWidth;
    localparam logic [CountWidth-1:0] CountMax = '1;

    // Report FSM state, visible by hierarchical reference for checkers.
    rpt_state_e state;

    logic [IdWidth-1:0]    err_idx;
    logic                  err_found;
    logic [IdWidth-1:0]    pend_idx;
    logic                  pend_found;
    logic                  handshake;
    logic [NumSources-1:0] report_mask;
    logic [PopWidth-1:0]   pop;
    logic [SumWidth-1:0]   sum;
    logic [CountWidth-1:0] count_next;

    br_err_event_log_prio_enc #(.NumSources(NumSources)) u_first_enc (
        .vec   (err_in),
        .idx   (err_idx),
        .found (err_found)
    );

    br_err_event_log_prio_enc #(.NumSources(NumSources)) u_pend_enc (
        .vec   (pending),
        .idx   (pend_idx),
        .found (pend_found)
    );

    assign rpt_valid   = (state == OFFER);
    assign handshake   = rpt_valid && rpt_ready;
    assign report_mask = handshake ? (NumSources'(1) << rpt_id) : '0;
    assign any_err     = |pending;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NumSources; i++) begin
            pop = pop + PopWidth'(err_in[i]);
        end
        sum        = SumWidth'(err_count) + SumWidth'(pop);
        count_next = (sum > SumWidth'(CountMax)) ? CountMax : sum[CountWidth-1:0];
    end

    // A new error on the reported source re-sets its bit after the report clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pending     <= '0;
            err_count   <= '0;
            first_valid <= 1'b0;
            first_id    <= '0;
            rpt_id      <= '0;
            state       <= IDLE;
        end else begin
            pending   <= (pending & ~report_mask) | err_in;
            err_count <= count_next;
            if (!first_valid && err_found) begin
                first_valid <= 1'b1;
                first_id    <= err_idx;
            end
            case (state)
                IDLE: begin
                    if (pend_found) begin
                        rpt_id <= pend_idx;
                        state  <= OFFER;
                    end
                end
                OFFER: begin
                    if (rpt_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BR_ERR_EVENT_LOG_TIMESTAMP_EN
    logic [TimeWidth-1:0] cycle_cnt;

    // Free-running stamp; clear leaves it alone so stamps stay relative to reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + TimeWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            first_time <= '0;
        end else if (!first_valid && err_found) begin
            first_time <= cycle_cnt;
        end
    end
`else
    assign first_time = '0;
`endif

    a_num_sources : assert property (@(posedge clk) NumSources >= 2);

    a_offer_stable : assert property (@(posedge clk) disable iff (rst)
        rpt_valid && !rpt_ready && !clear |=> rpt_valid && $stable(rpt_id));

    a_offer_pending : assert property (@(posedge clk) disable iff (rst)
        rpt_valid |-> pending[rpt_id]);

endmodule
